// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and default data-memory geometry.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] ICMOVXX = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam int DEFAULT_MEM_BYTES = 1024;
  localparam int DEFAULT_WORD_BYTES = 8;

endpackage

// File: rtl/y86_memory_if.sv
// Memory-stage bus: execute-side operands in, loaded value and range error out.
interface y86_memory_if;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic [63:0] valM;
  logic        dmem_error;

  modport master (output icode, valA, valE, valP, input valM, dmem_error);
  modport slave  (input icode, valA, valE, valP, output valM, dmem_error);
endinterface

// File: rtl/y86_dmem.sv
// Byte-addressed data memory: async clear, 8-byte little-endian combinational read and clocked write.
module y86_dmem
  import y86_pkg::*;
#(
  parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
  parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [AW-1:0]             addr,
  input  logic [8*WORD_BYTES-1:0]   wdata,
  output logic [8*WORD_BYTES-1:0]   rdata
);

  logic [7:0]              mem_r [MEM_BYTES];
  logic [8*WORD_BYTES-1:0] rdata_s;

  // Byte array storage; caller guarantees addr+WORD_BYTES-1 is in range when we is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem_r[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // Little-endian gather of WORD_BYTES consecutive bytes.
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rdata_s[8*i +: 8] = mem_r[addr + AW'(i)];
    end
  end

  assign rdata = rdata_s;

endmodule

// File: rtl/y86_memory.sv
// SEQ Y86-64 memory stage: icode decode, full-width range check, and data memory access.
module y86_memory
  import y86_pkg::*;
#(
  parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
  parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  y86_memory_if.slave  bus
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES - WORD_BYTES);

  logic        rd_en_s;
  logic        wr_en_s;
  logic [63:0] mem_addr_s;
  logic [63:0] wdata_s;
  logic [63:0] rdata_s;
  logic        addr_err_s;
  logic        dmem_we_s;
  logic [63:0] val_m_s;

  // Address, data and enable selection from icode.
  always_comb begin
    rd_en_s    = 1'b0;
    wr_en_s    = 1'b0;
    mem_addr_s = 64'd0;
    wdata_s    = 64'd0;
    case (bus.icode)
      IRMMOVQ, IPUSHQ: begin
        wr_en_s    = 1'b1;
        mem_addr_s = bus.valE;
        wdata_s    = bus.valA;
      end
      ICALL: begin
        wr_en_s    = 1'b1;
        mem_addr_s = bus.valE;
        wdata_s    = bus.valP;
      end
      IMRMOVQ: begin
        rd_en_s    = 1'b1;
        mem_addr_s = bus.valE;
      end
      IRET, IPOPQ: begin
        rd_en_s    = 1'b1;
        mem_addr_s = bus.valA;
      end
      default: begin
        rd_en_s    = 1'b0;
        wr_en_s    = 1'b0;
      end
    endcase
  end

  // Full 64-bit compare so huge addresses flag instead of wrapping into the array.
  always_comb begin
    if (rst_n && (rd_en_s || wr_en_s) && (mem_addr_s > ADDR_LIMIT)) begin
      addr_err_s = 1'b1;
    end else begin
      addr_err_s = 1'b0;
    end
  end

  // Read result is suppressed on error, non-read icodes and during reset.
  always_comb begin
    if (rst_n && rd_en_s && !addr_err_s) begin
      val_m_s = rdata_s;
    end else begin
      val_m_s = 64'd0;
    end
  end

  assign dmem_we_s      = rst_n & wr_en_s & ~addr_err_s;
  assign bus.valM       = val_m_s;
  assign bus.dmem_error = addr_err_s;

  y86_dmem #(
    .MEM_BYTES  (MEM_BYTES),
    .WORD_BYTES (WORD_BYTES)
  ) u_dmem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (dmem_we_s),
    .addr  (mem_addr_s[AW-1:0]),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

endmodule

// File: tb/tb_y86_memory.sv
// Directed table-driven bench for the Y86-64 memory stage plus reset corner sequences.
module tb_y86_memory;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  y86_memory_if bus ();

  y86_memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] val_a;
    logic [63:0] val_e;
    logic [63:0] val_p;
    logic [63:0] exp_m;
    logic        exp_err;
  } vec_t;

  vec_t vecs [25];

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p);
    bus.icode = ic;
    bus.valA  = a;
    bus.valE  = e;
    bus.valP  = p;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(4'd5, 64'd0, 64'd0, 64'd0);
    rst_n = 1'b0;
    #2;
    check64("reset_valM", bus.valM, 64'd0);
    bus.icode = 4'd4;
    bus.valE  = 64'd1200;
    #1;
    check1("reset_err_masked", bus.dmem_error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = '{4'd4,  64'd100, 64'd24, 64'd0, 64'd0, 1'b0};
    vecs[1]  = '{4'd5,  64'd0, 64'd24, 64'd0, 64'd100, 1'b0};
    vecs[2]  = '{4'd5,  64'd0, 64'd8, 64'd0, 64'd0, 1'b0};
    vecs[3]  = '{4'd8,  64'd5, 64'd32, 64'd64, 64'd0, 1'b0};
    vecs[4]  = '{4'd9,  64'd32, 64'd0, 64'd0, 64'd64, 1'b0};
    vecs[5]  = '{4'd10, 64'd10, 64'd20, 64'd99, 64'd0, 1'b0};
    vecs[6]  = '{4'd11, 64'd20, 64'd0, 64'd0, 64'd10, 1'b0};
    vecs[7]  = '{4'd5,  64'd0, 64'd24, 64'd0, 64'd0, 1'b0};
    vecs[8]  = '{4'd4,  64'hDEAD_BEEF_0BAD_F00D, 64'd1200, 64'd0, 64'd0, 1'b1};
    vecs[9]  = '{4'd5,  64'd0, 64'd1016, 64'd0, 64'd0, 1'b0};
    vecs[10] = '{4'd5,  64'd0, 64'd1017, 64'd0, 64'd0, 1'b1};
    vecs[11] = '{4'd4,  64'h1122_3344_5566_7788, 64'd1016, 64'd0, 64'd0, 1'b0};
    vecs[12] = '{4'd5,  64'd0, 64'd1016, 64'd0, 64'h1122_3344_5566_7788, 1'b0};
    vecs[13] = '{4'd5,  64'd0, 64'd1012, 64'd0, 64'h5566_7788_0000_0000, 1'b0};
    vecs[14] = '{4'd5,  64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1};
    vecs[15] = '{4'd4,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1};
    vecs[16] = '{4'd5,  64'd0, 64'd0, 64'd0, 64'd0, 1'b0};
    vecs[17] = '{4'd3,  64'd1, 64'd1, 64'd0, 64'd0, 1'b0};
    vecs[18] = '{4'd5,  64'd0, 64'd1, 64'd0, 64'd0, 1'b0};
    vecs[19] = '{4'd9,  64'd32, 64'd0, 64'd0, 64'd64, 1'b0};
    vecs[20] = '{4'd0,  64'd32, 64'd32, 64'd0, 64'd0, 1'b0};
    vecs[21] = '{4'd11, 64'd1200, 64'd0, 64'd0, 64'd0, 1'b1};
    vecs[22] = '{4'd10, 64'hA5, 64'h1_0000_0000, 64'd0, 64'd0, 1'b1};
    vecs[23] = '{4'd7,  64'd0, 64'd1200, 64'd0, 64'd0, 1'b0};
    vecs[24] = '{4'd5,  64'd0, 64'd0, 64'd0, 64'd0, 1'b0};

    // Each vector settles mid-low-phase, is checked, then crosses one rising edge.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vecs[i].icode, vecs[i].val_a, vecs[i].val_e, vecs[i].val_p);
      #2;
      check64($sformatf("vec%0d_valM", i), bus.valM, vecs[i].exp_m);
      check1($sformatf("vec%0d_err", i), bus.dmem_error, vecs[i].exp_err);
      @(posedge clk);
    end

    // Asynchronous reset mid-sequence, away from any clock edge.
    @(negedge clk);
    drive(4'd9, 64'd32, 64'd0, 64'd0);
    #1;
    check64("pre_reset_ret", bus.valM, 64'd64);
    rst_n = 1'b0;
    #1;
    check64("async_reset_valM", bus.valM, 64'd0);
    drive(4'd4, 64'd7, 64'd40, 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.valE = 64'd2000;
    #1;
    check1("reset_range_err_masked", bus.dmem_error, 1'b0);
    rst_n = 1'b1;
    drive(4'd9, 64'd32, 64'd0, 64'd0);
    #1;
    check64("post_reset_ret", bus.valM, 64'd0);
    drive(4'd5, 64'd0, 64'd40, 64'd0);
    #1;
    check64("reset_blocked_write", bus.valM, 64'd0);
    drive(4'd5, 64'd0, 64'd1016, 64'd0);
    #1;
    check64("post_reset_high", bus.valM, 64'd0);

    // Write after reset must land and be visible in the following cycle.
    @(negedge clk);
    drive(4'd4, 64'h0123_4567_89AB_CDEF, 64'd3, 64'd0);
    @(posedge clk);
    @(negedge clk);
    drive(4'd5, 64'd0, 64'd3, 64'd0);
    #1;
    check64("post_reset_write", bus.valM, 64'h0123_4567_89AB_CDEF);
    drive(4'd5, 64'd0, 64'd7, 64'd0);
    #1;
    check64("unaligned_read", bus.valM, 64'h0000_0000_0123_4567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
